commit_trace_buffer: RTL

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/trace_pkg.sv | 36 +++
 rtl/trace_ram.sv | 27 ++
 rtl/commit_trace_buffer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace buffer.
// Optional build macro TRACE_CYCLE_STAMP_EN adds a 32-bit cycle stamp field
// to every record.
package trace_pkg;

    // Reference datapath width for the canonical record layout.
    localparam int unsigned TRACE_XLEN = 32;

    // Behaviour when a capture arrives while the buffer is full.
    localparam int unsigned TRACE_WRAP = 32'd1;  // overwrite oldest record
    localparam int unsigned TRACE_STOP = 32'd0;  // drop the newest record

`ifdef TRACE_CYCLE_STAMP_EN
    localparam int unsigned STAMP_W = 32;
`else
    localparam int unsigned STAMP_W = 0;
`endif

    // Canonical record layout, MSB first: pc, instr, rd, we, wdata, [stamp].
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic [4:0]            rd;
        logic                  we;
        logic [TRACE_XLEN-1:0] wdata;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0]           stamp;
`endif
    } trace_rec_t;

    // Packed record width for an arbitrary datapath width.
    function automatic int unsigned rec_width(input int unsigned xlen);
        return (32'd2 * xlen) + 32'd38 + STAMP_W;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Record storage for the commit trace buffer: DEPTH entries, one synchronous
// write port and one asynchronous read port. Contents have no reset, so they
// survive both rst_n and the synchronous clear.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 102
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write one record per enabled rising edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retired-instruction records into a circular
// buffer and presents the oldest one on a valid/ready read port.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// Optional build macro TRACE_CYCLE_STAMP_EN adds a free-running cycle counter
// whose value is stored with each record and presented on rd_stamp.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WRAP_MODE = 32'd1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     cap_en,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [31:0]              ret_instr,
    input  logic [4:0]               ret_rd,
    input  logic [XLEN-1:0]          ret_wdata,
    input  logic                     ret_we,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_instr,
    output logic [4:0]               rd_rd,
    output logic [XLEN-1:0]          rd_wdata,
    output logic                     rd_we,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [31:0]              rd_stamp,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned REC_W = rec_width(XLEN);
    localparam int unsigned S     = STAMP_W;

    // Field offsets inside the stored record (stamp occupies the low bits).
    localparam int unsigned OFF_WDATA = S;
    localparam int unsigned OFF_WE    = S + XLEN;
    localparam int unsigned OFF_RD    = S + XLEN + 1;
    localparam int unsigned OFF_INSTR = S + XLEN + 6;
    localparam int unsigned OFF_PC    = S + XLEN + 38;

    logic [PW-1:0]    wptr_q,  wptr_d;
    logic [PW-1:0]    rptr_q,  rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q,   ovf_d;
    logic             valid_q;

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             ram_we_s;
    logic             rec_we_s;
    logic [REC_W-1:0] wr_rec_s;
    logic [REC_W-1:0] rd_rec_s;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]      cycle_q;

    // Free-running cycle counter; only rst_n restarts it, clear does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end
`endif

    // clear acts as the synchronous flush and blocks both push and pop.
    assign push_s   = ret_valid & cap_en & ~clear;
    assign pop_s    = valid_q & rd_ready & ~clear;
    assign full_s   = (count_q == CW'(DEPTH));

    // Writes to x0 are architecturally invisible, so never report them.
    assign rec_we_s = ret_we & (ret_rd != 5'd0);

`ifdef TRACE_CYCLE_STAMP_EN
    assign wr_rec_s = {ret_pc, ret_instr, ret_rd, rec_we_s, ret_wdata, cycle_q};
`else
    assign wr_rec_s = {ret_pc, ret_instr, ret_rd, rec_we_s, ret_wdata};
`endif

    // Pointer, occupancy and overflow bookkeeping for the next edge.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ram_we_s = 1'b0;
        if (clear) begin
            wptr_d  = {PW{1'b0}};
            rptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
            ovf_d   = 1'b0;
        end else begin
            if (push_s && pop_s) begin
                // Pop frees a slot first, so even a full buffer keeps the
                // new record without loss and overflow is untouched.
                ram_we_s = 1'b1;
                wptr_d   = wptr_q + PW'(1);
                rptr_d   = rptr_q + PW'(1);
            end else if (push_s && !full_s) begin
                ram_we_s = 1'b1;
                wptr_d   = wptr_q + PW'(1);
                count_d  = count_q + CW'(1);
            end else if (push_s && (WRAP_MODE == TRACE_WRAP)) begin
                // Full: write over the oldest slot (wptr == rptr here).
                ram_we_s = 1'b1;
                wptr_d   = wptr_q + PW'(1);
                rptr_d   = rptr_q + PW'(1);
                ovf_d    = 1'b1;
            end else if (push_s) begin
                // Full in stop mode: the new record is discarded.
                ovf_d    = 1'b1;
            end else if (pop_s) begin
                rptr_d   = rptr_q + PW'(1);
                count_d  = count_q - CW'(1);
            end else begin
                count_d  = count_q;
            end
        end
    end

    // Bookkeeping registers; rst_n discards every held record immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= (count_d != {CW{1'b0}});
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (wptr_q),
        .wdata_i (wr_rec_s),
        .raddr_i (rptr_q),
        .rdata_o (rd_rec_s)
    );

    assign rd_valid = valid_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_pc    = rd_rec_s[OFF_PC    +: XLEN];
    assign rd_instr = rd_rec_s[OFF_INSTR +: 32];
    assign rd_rd    = rd_rec_s[OFF_RD    +: 5];
    assign rd_we    = rd_rec_s[OFF_WE];
    assign rd_wdata = rd_rec_s[OFF_WDATA +: XLEN];
`ifdef TRACE_CYCLE_STAMP_EN
    assign rd_stamp = rd_rec_s[31:0];
`endif

endmodule
